// File: rtl/deskew_ctrl.sv
// deskew_ctrl: measures per-lane alignment-marker arrival and loads equalising FIFO delays.
// Optional DESKEW_ERR_CNT_EN adds a saturating count of deskew-error pulses.
module deskew_ctrl #(
  parameter int N_LANES  = 20,
  parameter int MAX_SKEW = 16,
  parameter int NB_DELAY = $clog2(MAX_SKEW),
  parameter int NB_ERR   = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_resync,
  input  logic [N_LANES-1:0]           i_am_lock,
  input  logic [N_LANES-1:0]           i_start_of_lane,
  output logic [N_LANES*NB_DELAY-1:0]  o_lane_delay,
  output logic                         o_set_fifo_delay,
  output logic                         o_align_status,
  output logic                         o_valid_skew,
  output logic                         o_deskew_error,
  output logic [NB_ERR-1:0]            o_error_count
);
  localparam logic [3:0] WAIT_LOCK  = 4'b0001;
  localparam logic [3:0] WAIT_FIRST = 4'b0010;
  localparam logic [3:0] COUNT      = 4'b0100;
  localparam logic [3:0] DONE       = 4'b1000;
  logic [3:0] state_q, state_d;
  logic [N_LANES-1:0] seen_q, seen_d, new_lanes;
  logic [NB_DELAY-1:0] cnt_q, cnt_d, skew;
  logic [NB_DELAY-1:0] arr_q [N_LANES];
  logic [NB_DELAY-1:0] arr_d [N_LANES];
  logic [N_LANES*NB_DELAY-1:0] delay_q, delay_d;
  logic set_q, set_d, align_q, align_d, valid_q, valid_d, err_q, err_d, done;
  assign new_lanes = i_start_of_lane & ~seen_q;
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    arr_d   = arr_q;
    delay_d = delay_q;
    align_d = align_q;
    valid_d = valid_q;
    set_d   = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;
    skew    = '0;
    if (i_resync || (i_enable && !(&i_am_lock))) begin
      state_d = WAIT_LOCK;
      seen_d  = '0;
      cnt_d   = '0;
      align_d = 1'b0;
      valid_d = 1'b0;
    end else if (i_enable) begin
      case (state_q)
        WAIT_LOCK: state_d = WAIT_FIRST;
        WAIT_FIRST: if (|i_start_of_lane) begin
          seen_d = i_start_of_lane;
          cnt_d  = NB_DELAY'(1);
          for (int i = 0; i < N_LANES; i++) if (i_start_of_lane[i]) arr_d[i] = '0;
          state_d = COUNT;
          done    = &i_start_of_lane;
        end
        COUNT: begin
          seen_d = seen_q | new_lanes;
          for (int i = 0; i < N_LANES; i++) if (new_lanes[i]) arr_d[i] = cnt_q;
          if (&(seen_q | new_lanes)) begin
            done = 1'b1;
            skew = cnt_q;
          end else if (cnt_q == NB_DELAY'(MAX_SKEW - 1)) begin
            err_d   = 1'b1;
            seen_d  = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = WAIT_FIRST;
          end else cnt_d = cnt_q + NB_DELAY'(1);
        end
        DONE: ;
        default: state_d = WAIT_LOCK;
      endcase
      // arrival never exceeds skew, so the subtraction cannot underflow
      if (done) begin
        state_d = DONE;
        set_d   = 1'b1;
        align_d = 1'b1;
        valid_d = 1'b1;
        for (int i = 0; i < N_LANES; i++) delay_d[i*NB_DELAY +: NB_DELAY] = skew - arr_d[i];
      end
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= WAIT_LOCK;
      seen_q  <= '0;
      cnt_q   <= '0;
      arr_q   <= '{default: '0};
      delay_q <= '0;
      set_q   <= 1'b0;
      align_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      arr_q   <= arr_d;
      delay_q <= delay_d;
      set_q   <= set_d;
      align_q <= align_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
`ifdef DESKEW_ERR_CNT_EN
  logic [NB_ERR-1:0] err_cnt_q;
  always_ff @(posedge i_clock) begin
    if (i_reset) err_cnt_q <= '0;
    else if (err_d && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + NB_ERR'(1);
  end
  assign o_error_count = err_cnt_q;
`else
  assign o_error_count = '0;
`endif
  assign o_lane_delay     = delay_q;
  assign o_set_fifo_delay = set_q;
  assign o_align_status   = align_q;
  assign o_valid_skew     = valid_q;
  assign o_deskew_error   = err_q;
endmodule

// File: tb/tb_deskew_ctrl.sv
// tb_deskew_ctrl: directed and randomized deskew runs against an arrival-offset model.
module tb_deskew_ctrl;
  localparam int NL = 4;
  localparam int MS = 16;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst, en, resync;
  logic [NL-1:0] lock, sol;
  logic [NL*NB-1:0] delay;
  logic set_p, align, valid, derr;
  logic [7:0] ecnt;
  int npass = 0, ntot = 0;
  int off[NL];
  int drop_at = -1;
  int exp_errs = 0;
  logic [NL*NB-1:0] held = '0;
  always #5 clk = ~clk;
  deskew_ctrl #(.N_LANES(NL), .MAX_SKEW(MS), .NB_DELAY(NB), .NB_ERR(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_resync(resync),
    .i_am_lock(lock), .i_start_of_lane(sol), .o_lane_delay(delay),
    .o_set_fifo_delay(set_p), .o_align_status(align), .o_valid_skew(valid),
    .o_deskew_error(derr), .o_error_count(ecnt));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step(input logic e, input logic [NL-1:0] s);
    en = e;
    sol = s;
    @(posedge clk);
    #1;
  endtask
  // Arrival offsets in off[] are enabled cycles after the first marker; 99 means the lane never arrives.
  task automatic run(input bit rand_en, input bit do_resync);
    int mx, t, early, iter;
    bit err;
    logic e;
    logic [NL-1:0] s;
    logic [NL*NB-1:0] exp_d;
    mx = 0;
    for (int i = 0; i < NL; i++) if (off[i] > mx) mx = off[i];
    err = mx >= MS;
    if (do_resync) begin
      resync = 1'b1;
      step(1'($urandom % 2), '0);
      resync = 1'b0;
      check("resync_align", 32'(align), 32'(0));
      check("resync_delay_held", 32'(delay), 32'(held));
    end
    step(1'b1, '0);
    step(1'b1, '0);
    t = 0;
    early = 0;
    iter = 0;
    while (iter < 400) begin
      iter++;
      e = rand_en ? 1'($urandom % 2) : 1'b1;
      for (int i = 0; i < NL; i++) s[i] = e ? (off[i] == t) : 1'($urandom % 2);
      lock = (e && t == drop_at) ? 4'b1011 : 4'b1111;
      step(e, s);
      if (e && t == (err ? MS - 1 : mx)) break;
      if (set_p || derr) early++;
      if (e) t++;
    end
    lock = 4'b1111;
    check("run_bounded", 32'(iter < 400), 32'(1));
    check("no_early_pulse", 32'(early), 32'(0));
    if (drop_at >= 0) begin
      check("lockloss_no_set", 32'(set_p), 32'(0));
      check("lockloss_align", 32'(align), 32'(0));
      check("lockloss_valid", 32'(valid), 32'(0));
      check("lockloss_delay_held", 32'(delay), 32'(held));
      drop_at = -1;
    end else if (err) begin
      check("err_pulse", 32'(derr), 32'(1));
      check("err_no_set", 32'(set_p), 32'(0));
      check("err_valid", 32'(valid), 32'(0));
`ifdef DESKEW_ERR_CNT_EN
      if (exp_errs < 255) exp_errs++;
`endif
      check("err_count", 32'(ecnt), 32'(exp_errs));
      step(1'($urandom % 2), '0);
      check("err_pulse_clears", 32'(derr), 32'(0));
    end else begin
      for (int i = 0; i < NL; i++) exp_d[i*NB +: NB] = 4'(mx - off[i]);
      check("set_pulse", 32'(set_p), 32'(1));
      check("align", 32'(align), 32'(1));
      check("valid", 32'(valid), 32'(1));
      check("delays", 32'(delay), 32'(exp_d));
      held = exp_d;
      repeat (3) step(1'($urandom % 2), 4'($urandom));
      check("set_pulse_clears", 32'(set_p), 32'(0));
      check("done_holds_delay", 32'(delay), 32'(held));
      check("done_holds_align", 32'(align), 32'(1));
    end
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    resync = 1'b0;
    lock = '0;
    sol = '0;
    step(1'b0, '0);
    step(1'b1, '0);
    rst = 1'b0;
    step(1'b1, '0);
    check("rst_delay", 32'(delay), 32'(0));
    check("rst_set", 32'(set_p), 32'(0));
    check("rst_align", 32'(align), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_err", 32'(derr), 32'(0));
    check("rst_ecnt", 32'(ecnt), 32'(0));
    lock = 4'b1111;
    off = '{0, 2, 5, 7};
    run(1'b0, 1'b1);
    check("scn1_delays", 32'(delay), 32'h0257);
    run(1'b1, 1'b1);
    check("scn1_gated_delays", 32'(delay), 32'h0257);
    off = '{0, 0, 0, 0};
    run(1'b0, 1'b1);
    off = '{0, 99, 99, 99};
    run(1'b0, 1'b1);
    off = '{0, 3, 1, 2};
    run(1'b0, 1'b0);
    off = '{0, 1, 2, 3};
    drop_at = 3;
    run(1'b0, 1'b1);
    off = '{1, 0, 2, 2};
    run(1'b1, 1'b0);
    off = '{0, 2, 1, 4};
    run(1'b0, 1'b1);
    check("skew4_lane0", 32'(delay[3:0]), 32'(4));
    check("skew4_lane3", 32'(delay[15:12]), 32'(0));
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < NL; i++) off[i] = int'($urandom_range(0, MS - 1));
      off[$urandom_range(0, NL - 1)] = 0;
      if ($urandom_range(0, 4) == 0) off[$urandom_range(1, NL - 1)] = 99;
      run(1'($urandom % 2), 1'b1);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
